// File: rtl/imem_loader_pkg.sv
// Shared loader/imem constants and loader state encodings.
// Keeps memory depth and load base address identical for the loader and the memory it fills.
package imem_loader_pkg;

    localparam int          IMEM_ADDR_W    = 10;
    localparam int          IMEM_DEPTH     = 2 ** IMEM_ADDR_W;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_DONE    = 2'd3
    } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs little-endian bytes into a 32-bit word; o_full flags the push that completes it.
// o_word is valid together with o_full (the fourth byte goes straight through); no backpressure of its own.
module imem_loader_byte_packer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic        o_full,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_lo;

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clr) begin
            r_cnt <= 2'd0;
            r_lo  <= 24'd0;
        end else if (i_push) begin
            case (r_cnt)
                2'd0:    r_lo[7:0]   <= i_byte;
                2'd1:    r_lo[15:8]  <= i_byte;
                2'd2:    r_lo[23:16] <= i_byte;
                default: ;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // The top lane is never stored: the word is consumed on the push that fills it.
    assign o_full = i_push && (r_cnt == 2'd3);
    assign o_word = {i_byte, r_lo};

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, holding the core in reset while busy.
// we rises the cycle after the 4th byte of a word; in_valid low stalls the load indefinitely.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter logic [31:0] BASE_ADDR = IMEM_BASE_ADDR
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len_words,
    input  logic              i_abort,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_we,
    output logic [31:0]       o_waddr,
    output logic [31:0]       o_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    ld_state_t       r_state;
    logic            r_in_ready;
    logic            r_we;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [31:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic [ADDR_W:0] r_word_cnt;
    logic [ADDR_W:0] r_len;

    logic            w_push;
    logic            w_clr;
    logic            w_full;
    logic [31:0]     w_word;
    logic [ADDR_W:0] w_cnt_nxt;

    // abort wins over a same-cycle byte: the byte is simply not taken.
    assign w_push    = (r_state == LD_COLLECT) && i_in_valid && !i_abort;
    assign w_clr     = (r_state == LD_IDLE);
    assign w_cnt_nxt = r_word_cnt + ONE;

    imem_loader_byte_packer u_packer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_byte  (i_in_data),
        .o_full  (w_full),
        .o_word  (w_word)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= LD_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_waddr    <= BASE_ADDR;
            r_wdata    <= 32'd0;
            r_word_cnt <= '0;
            r_len      <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (i_start) begin
                        if (i_len_words == '0) begin
                            r_state <= LD_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_err   <= 1'b0;
                        end else if (i_len_words > DEPTH) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state    <= LD_COLLECT;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                            r_word_cnt <= '0;
                            r_len      <= i_len_words;
                        end
                    end
                end
                LD_COLLECT: begin
                    if (i_abort) begin
                        r_state    <= LD_IDLE;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_full) begin
                        r_state    <= LD_WRITE;
                        r_in_ready <= 1'b0;
                        r_we       <= 1'b1;
                        r_waddr    <= BASE_ADDR + 32'({r_word_cnt, 2'b00});
                        r_wdata    <= w_word;
                    end
                end
                LD_WRITE: begin
                    if (i_abort) begin
                        r_state <= LD_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_word_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= LD_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= LD_COLLECT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                LD_DONE: begin
                    r_state <= LD_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= LD_IDLE;
            endcase
        end
    end

    // The memory captures we at the edge closing WRITE; abort or reset seen in that cycle cancels it.
    assign o_we       = r_we && i_reset && !i_abort;
    assign o_in_ready = r_in_ready;
    assign o_waddr    = r_waddr;
    assign o_wdata    = r_wdata;
    assign o_cpu_hold = r_busy;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-load vectors plus abort and reset-in-WRITE sequences.
module tb_imem_loader;

    localparam int          AW   = 2;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_abort, i_in_valid;
    logic [AW:0]   i_len_words;
    logic [7:0]    i_in_data;
    logic          o_in_ready, o_we, o_cpu_hold, o_busy, o_done, o_err;
    logic [31:0]   o_waddr, o_wdata;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_len_words (i_len_words),
        .i_abort     (i_abort),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_cpu_hold  (o_cpu_hold),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor samples one time unit before each rising edge.
    int          cyc = 0;
    logic [31:0] we_addr_q[$];
    logic [31:0] we_data_q[$];
    int          we_cyc_q[$];
    int          done_cnt, done_cyc, xfer_cnt, rdy_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #4;
        if (o_we) begin
            we_addr_q.push_back(o_waddr);
            we_data_q.push_back(o_wdata);
            we_cyc_q.push_back(cyc);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (i_in_valid && o_in_ready && !i_abort) xfer_cnt++;
        if (o_in_ready) rdy_cnt++;
    end

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        we_cyc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        xfer_cnt = 0;
        rdy_cnt  = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd0);
        chk({tag, "_we"},       32'(o_we),       32'd0);
        chk({tag, "_cpu_hold"}, 32'(o_cpu_hold), 32'd0);
        chk({tag, "_busy"},     32'(o_busy),     32'd0);
        chk({tag, "_done"},     32'(o_done),     32'd0);
        chk({tag, "_err"},      32'(o_err),      32'd0);
        chk({tag, "_waddr"},    o_waddr,         BASE);
        chk({tag, "_wdata"},    o_wdata,         32'd0);
    endtask

    // Called at a falling edge; runs one complete load and checks the result.
    task automatic run_load(input string tag, input logic [AW:0] len, input bit gap,
                            input logic [3:0][31:0] w, input bit exp_err);
        int  bi;
        int  nbytes;
        int  start_cyc;
        int  nw;
        bit  fin;
        logic vld;
        clear_mon();
        nbytes      = exp_err ? 0 : 4 * int'(len);
        nw          = exp_err ? 0 : int'(len);
        i_start     = 1'b1;
        i_len_words = len;
        start_cyc   = cyc;
        @(negedge clk);
        i_start = 1'b0;
        chk({tag, "_hold_on"}, 32'(o_cpu_hold), 32'(!exp_err));
        chk({tag, "_busy_on"}, 32'(o_busy),     32'(!exp_err));
        bi  = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            vld        = gap ? (c % 2 == 0) : 1'b1;
            i_in_valid = vld;
            i_in_data  = (bi < nbytes) ? w[bi / 4][(bi % 4) * 8 +: 8] : 8'hEE;
            if (vld && o_in_ready) bi++;
            @(negedge clk);
            if (exp_err ? (c >= 5) : (done_cnt > 0)) fin = 1'b1;
        end
        i_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_writes"}, 32'(we_addr_q.size()), 32'(nw));
        for (int i = 0; i < we_addr_q.size() && i < nw; i++) begin
            chk({tag, "_waddr"}, we_addr_q[i], BASE + 32'(4 * i));
            chk({tag, "_wdata"}, we_data_q[i], w[i]);
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(!exp_err));
        chk({tag, "_xfers"},    32'(xfer_cnt), 32'(nbytes));
        if (!exp_err && len == 0) begin
            chk({tag, "_rdy_never"}, 32'(rdy_cnt), 32'd0);
            chk({tag, "_done_lat"},  32'(done_cyc - start_cyc), 32'd1);
        end
        if (nw > 0 && we_cyc_q.size() > 0) begin
            chk({tag, "_done_after_we"}, 32'(done_cyc - we_cyc_q[we_cyc_q.size() - 1]), 32'd1);
            chk({tag, "_waddr_hold"}, o_waddr, BASE + 32'(4 * (nw - 1)));
            chk({tag, "_wdata_hold"}, o_wdata, w[nw - 1]);
        end
        chk({tag, "_hold_off"}, 32'(o_cpu_hold), 32'd0);
        chk({tag, "_busy_off"}, 32'(o_busy),     32'd0);
        chk({tag, "_err"},      32'(o_err),      32'(exp_err));
    endtask

    typedef struct {
        string             tag;
        logic [AW:0]       len;
        bit                gap;
        logic [3:0][31:0]  words;
        bit                exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  bi;
        bit  found;
        logic [1:0][31:0] rw;

        vecs[0] = '{"b2b_len2",  3'd2, 1'b0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h12345678}, 1'b0};
        vecs[1] = '{"gap_len1",  3'd1, 1'b1, {32'h0, 32'h0, 32'h0, 32'hA5A55A5A}, 1'b0};
        vecs[2] = '{"len0",      3'd0, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
        vecs[3] = '{"too_long",  3'd5, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
        vecs[4] = '{"err_clear", 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h0BADF00D}, 1'b0};
        vecs[5] = '{"full_depth",3'd4, 1'b0, {32'h00FFEEDD, 32'hCCBBAA99, 32'h88776655, 32'h44332211}, 1'b0};
        vecs[6] = '{"gap_len3",  3'd3, 1'b1, {32'h0, 32'hCAFEF00D, 32'h07060504, 32'h03020100}, 1'b0};

        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = 8'h00;
        i_len_words = '0;
        clear_mon();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        i_reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++)
            run_load(vecs[v].tag, vecs[v].len, vecs[v].gap, vecs[v].words, vecs[v].exp_err);

        // Abort mid-word 1 of a 3-word load, with a byte offered in the same cycle.
        clear_mon();
        i_start     = 1'b1;
        i_len_words = 3'd3;
        @(negedge clk);
        i_start = 1'b0;
        bi = 0;
        for (int c = 0; c < 50 && bi < 6; c++) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'h30 + 8'(bi);
            if (o_in_ready) bi++;
            @(negedge clk);
        end
        i_abort   = 1'b1;
        i_in_data = 8'h77;
        @(negedge clk);
        i_abort    = 1'b0;
        i_in_valid = 1'b0;
        chk("abort_hold_off", 32'(o_cpu_hold), 32'd0);
        chk("abort_busy_off", 32'(o_busy),     32'd0);
        chk("abort_rdy_off",  32'(o_in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_writes", 32'(we_addr_q.size()), 32'd1);
        if (we_addr_q.size() > 0) begin
            chk("abort_waddr", we_addr_q[0], BASE);
            chk("abort_wdata", we_data_q[0], 32'h33323130);
        end
        chk("abort_done",  32'(done_cnt), 32'd0);
        chk("abort_xfers", 32'(xfer_cnt), 32'd6);
        chk("abort_err",   32'(o_err),    32'd0);

        // Reset pulled low while word 1 is in WRITE.
        clear_mon();
        rw = {32'h1A1B1C1D, 32'h0A0B0C0D};
        i_start     = 1'b1;
        i_len_words = 3'd2;
        @(negedge clk);
        i_start = 1'b0;
        bi    = 0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (o_we && o_waddr == BASE + 32'd4) begin
                found = 1'b1;
            end else begin
                i_in_valid = 1'b1;
                i_in_data  = (bi < 8) ? rw[bi / 4][(bi % 4) * 8 +: 8] : 8'hEE;
                if (o_in_ready) bi++;
                @(negedge clk);
            end
        end
        chk("rst_reached_write", 32'(found), 32'd1);
        i_reset    = 1'b0;
        i_in_valid = 1'b0;
        #1;
        chk("rst_we_gated", 32'(o_we), 32'd0);
        @(negedge clk);
        check_reset_vals("rst_mid");
        i_reset = 1'b1;
        @(negedge clk);
        chk("rst_writes", 32'(we_addr_q.size()), 32'd1);
        chk("rst_done",   32'(done_cnt),         32'd0);
        run_load("after_rst", 3'd1, 1'b0, {32'h0, 32'h0, 32'h0, 32'h5EED1234}, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
